// File: rtl/sqrt_seq.sv
// rtl/sqrt_seq.sv - operand sequencer and result collector around the iterative sqrt core
//
// Accepts operands on a valid/ready input stream, buffers them in a small FIFO,
// launches one core computation at a time over the core's enb/busy handshake and
// returns {operand, root} pairs in issue order on a valid/ready output stream.
// A watchdog aborts an operation whose core never drops busy and raises a sticky
// error flag.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     operand valid
//   in_data_i      operand
//   in_ready_o     FIFO can accept (occupancy below DEPTH)
//   out_valid_o    result pair valid
//   out_ready_i    consumer accepts result
//   out_operand_o  operand that produced the result
//   out_root_o     core result, floor(sqrt(operand))
//   sq_enb_o       launch strobe to core enb_i
//   sq_dt_o        operand to core dt_i
//   sq_busy_i      core busy_o
//   sq_dt_i        core dt_o
//   count_o        FIFO occupancy
//   err_o          sticky watchdog error

module sqrt_seq #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    input  logic [DW-1:0]              in_data_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DW-1:0]              out_operand_o,
    output logic [DW-1:0]              out_root_o,
    output logic                       sq_enb_o,
    output logic [DW-1:0]              sq_dt_o,
    input  logic                       sq_busy_i,
    input  logic [DW-1:0]              sq_dt_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
    localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t         state;

    logic [DW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;

    logic [WDW-1:0] wd_q;

    logic           sq_enb_q;
    logic [DW-1:0]  sq_dt_q;
    logic           out_valid_q;
    logic [DW-1:0]  out_operand_q;
    logic [DW-1:0]  out_root_q;
    logic           err_q;

    logic           push;
    logic           pop;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never makes room for that cycle's push.
    assign in_ready_o = (count_q != FULL_CNT);
    assign push       = in_valid_i && in_ready_o;

    // The head is taken only when the core is idle, so the launch in ISSUE is
    // guaranteed to be seen by the core.
    assign pop        = (state == S_IDLE) && (count_q != '0) && !sq_busy_i;

    // FIFO storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer: all core-facing and result outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            wd_q          <= '0;
            sq_enb_q      <= 1'b0;
            sq_dt_q       <= '0;
            out_valid_q   <= 1'b0;
            out_operand_q <= '0;
            out_root_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        sq_dt_q  <= mem[rd_ptr];
                        sq_enb_q <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end

                // The core latches the operand on this cycle's closing edge;
                // enb is dropped so it cannot relaunch.
                S_ISSUE: begin
                    sq_enb_q <= 1'b0;
                    wd_q     <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (!sq_busy_i) begin
                        out_operand_q <= sq_dt_q;
                        out_root_q    <= sq_dt_i;
                        out_valid_q   <= 1'b1;
                        state         <= S_HOLD;
                    end else if (wd_q == WD_LIMIT) begin
                        // Core is stuck: drop this operand and move on.
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end

                S_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign count_o       = count_q;
    assign sq_enb_o      = sq_enb_q;
    assign sq_dt_o       = sq_dt_q;
    assign out_valid_o   = out_valid_q;
    assign out_operand_o = out_operand_q;
    assign out_root_o    = out_root_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// tb/tb_sqrt_seq.sv - directed self-checking bench for sqrt_seq with a behavioural sqrt core

module tb_sqrt_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_operand;
    logic [7:0] out_root;
    logic       sq_enb;
    logic [7:0] sq_dt;
    logic       core_busy;
    logic [7:0] core_dt;
    logic [2:0] count;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    // core model controls
    int fixed_lat = 0;
    bit rand_lat  = 0;
    bit long50    = 0;
    int core_cnt;

    // monitors
    logic [15:0] resq[$];
    int          enb_cnt = 0;
    logic [7:0]  last_enb_dt = 8'd0;

    sqrt_seq #(.DW(8), .DEPTH(4), .TIMEOUT_CYC(64)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .in_ready_o    (in_ready),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_operand_o (out_operand),
        .out_root_o    (out_root),
        .sq_enb_o      (sq_enb),
        .sq_dt_o       (sq_dt),
        .sq_busy_i     (core_busy),
        .sq_dt_i       (core_dt),
        .count_o       (count),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] isqrt(input logic [7:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return 8'(r);
    endfunction

    function automatic int pick_lat(input logic [7:0] d);
        if (long50 && d == 8'd50) return 100;
        if (rand_lat) return int'($urandom_range(0, 10));
        return fixed_lat;
    endfunction

    // Behavioural core: launches on enb while idle, busy for the chosen latency.
    assign core_busy = (core_cnt != 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt <= 0;
            core_dt  <= 8'd0;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end else if (sq_enb) begin
            core_cnt <= pick_lat(sq_dt);
            core_dt  <= isqrt(sq_dt);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) resq.push_back({out_operand, out_root});
            if (sq_enb) begin
                enb_cnt++;
                last_enb_dt = sq_dt;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d);
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            check("push_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input string tag, input int n, input int bound);
        int k = 0;
        while (resq.size() < n && k < bound) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, resq.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int e0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd77;
        out_ready = 1'b0;

        // 1: reset state with in_valid held high
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_sq_enb", sq_enb, 0);
        check("rst_sq_dt", sq_dt, 0);
        check("rst_err", err, 0);
        check("rst_operand", out_operand, 0);
        check("rst_root", out_root, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_count", count, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_enb_cnt", enb_cnt, 0);

        // 2: single operand, 8 busy cycles
        fixed_lat = 8;
        e0 = enb_cnt;
        @(posedge clk);
        #1;
        push(8'd200);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("lat_200", k, 11);
        check("enb_pulses_200", enb_cnt - e0, 1);
        check("enb_dt_200", last_enb_dt, 200);
        check("op_200", out_operand, 200);
        check("root_200", out_root, 14);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_200", out_valid, 0);
        resq.delete();

        // 3: sweep 0..255 back-to-back, random core latency
        rand_lat = 1;
        for (int x = 0; x < 256; x++) push(8'(x));
        wait_results("sweep_count", 256, 10000);
        for (int x = 0; x < 256 && x < resq.size(); x++) begin
            check($sformatf("sweep_op_%0d", x), resq[x][15:8], x);
            check($sformatf("sweep_root_%0d", x), resq[x][7:0], isqrt(8'(x)));
        end
        if (resq.size() == 256) begin
            check("root_255", resq[255][7:0], 15);
            check("root_0", resq[0][7:0], 0);
            check("root_1", resq[1][7:0], 1);
            check("root_16", resq[16][7:0], 4);
            check("root_15", resq[15][7:0], 3);
        end
        check("sweep_err", err, 0);
        rand_lat = 0;
        repeat (20) @(posedge clk);
        #1;

        // 4: backpressure, FIFO fill
        out_ready = 1'b0;
        fixed_lat = 2;
        resq.delete();
        push(8'd10);
        push(8'd20);
        push(8'd30);
        push(8'd40);
        push(8'd50);
        repeat (10) @(posedge clk);
        #1;
        check("bp_valid", out_valid, 1);
        check("bp_op", out_operand, 10);
        check("bp_root", out_root, 3);
        check("bp_count", count, 4);
        check("bp_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'd99;
        repeat (5) @(posedge clk);
        #1;
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_op", out_operand, 10);
        check("bp_hold_root", out_root, 3);
        check("bp_full_count", count, 4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_results("bp_drain", 5, 200);
        repeat (30) @(posedge clk);
        #1;
        check("bp_no_extra", resq.size(), 5);
        if (resq.size() >= 5) begin
            check("bp_r0", resq[0], {8'd10, 8'd3});
            check("bp_r1", resq[1], {8'd20, 8'd4});
            check("bp_r2", resq[2], {8'd30, 8'd5});
            check("bp_r3", resq[3], {8'd40, 8'd6});
            check("bp_r4", resq[4], {8'd50, 8'd7});
        end
        check("bp_empty", count, 0);

        // 5: stuck core on operand 50
        resq.delete();
        long50    = 1;
        fixed_lat = 1;
        push(8'd50);
        k = 0;
        while (!err && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("wd_err_lat", k, 66);
        check("wd_no_result", resq.size(), 0);
        check("wd_out_valid", out_valid, 0);
        push(8'd81);
        wait_results("wd_next_result", 1, 300);
        if (resq.size() >= 1) check("wd_r81", resq[0], {8'd81, 8'd9});
        check("wd_err_sticky", err, 1);
        long50 = 0;
        repeat (10) @(posedge clk);
        #1;

        // 6: reset during WAIT with three entries queued
        resq.delete();
        fixed_lat = 30;
        push(8'd11);
        push(8'd22);
        push(8'd33);
        push(8'd44);
        repeat (3) @(posedge clk);
        #1;
        check("mid_count", count, 3);
        check("mid_busy", core_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_enb", sq_enb, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_err", err, 0);
        repeat (3) @(posedge clk);
        #1;
        resq.delete();
        e0 = enb_cnt;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("post_rst_results", resq.size(), 0);
        check("post_rst_enb", enb_cnt - e0, 0);
        check("post_rst_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
